// File: rtl/pulse_train_gen.sv
// pulse_train_gen
//
// Serial transmitter of a binary count: after an accepted start it emits
// exactly count_in pulses on add_sig, which drives the clock pin of the
// asynchronous ripple counter (counter_asyn) at the far end. add_sig comes
// straight from a flop, so it is glitch-free and safe to use as a clock.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset (priority over everything)
//   start      request to send; accepted only in IDLE
//   count_in   number of pulses to send, sampled when start is accepted
//   hi_len     high cycles per pulse, sampled at start (0 acts as 1)
//   lo_len     low cycles after each pulse, sampled at start (0 acts as 1)
//   abort      cancels a train in progress (HIGH or LOW only)
//   add_sig    registered pulse train
//   busy       high while pulses (and their trailing low time) are running
//   done       one-cycle completion strobe; not raised after abort
//   sent_cnt   pulses issued in the current or last train
//   state_dbg  current FSM state encoding, for observation only
//
// Handshake: start is a single-cycle request with no ready. It takes effect
// only when the FSM sits in IDLE at that clock edge; in any other state it is
// dropped, never queued. The train's completion is reported by one done
// cycle, or silently by busy falling if it was aborted.
module pulse_train_gen #(
  parameter int REG_SIZE = 16,
  parameter int LEN_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [REG_SIZE-1:0] count_in,
  input  logic [LEN_SIZE-1:0] hi_len,
  input  logic [LEN_SIZE-1:0] lo_len,
  input  logic                abort,
  output logic                add_sig,
  output logic                busy,
  output logic                done,
  output logic [REG_SIZE-1:0] sent_cnt,
  output logic [2:0]          state_dbg
);

  // S_LOAD is the single cycle between latching the request and the first
  // rising edge of add_sig; it makes add_sig rise one edge after start is
  // accepted, with every output still coming straight from a flop.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HIGH = 3'd2,
    S_LOW  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q;
  logic [REG_SIZE-1:0] rem_q;
  logic [REG_SIZE-1:0] sent_q;
  logic [LEN_SIZE-1:0] hlen_q;
  logic [LEN_SIZE-1:0] llen_q;
  logic [LEN_SIZE-1:0] cnt_q;     // cycles spent so far in the current HIGH/LOW phase
  logic                add_q;
  logic                busy_q;
  logic                done_q;

  logic [LEN_SIZE-1:0] hlen_d;
  logic [LEN_SIZE-1:0] llen_d;

  // A zero length would give a pulse with no width; treat it as one cycle.
  always_comb begin
    hlen_d = (hi_len == '0) ? LEN_SIZE'(1) : hi_len;
    llen_d = (lo_len == '0) ? LEN_SIZE'(1) : lo_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      sent_q  <= '0;
      hlen_q  <= LEN_SIZE'(1);
      llen_q  <= LEN_SIZE'(1);
      cnt_q   <= '0;
      add_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q   <= count_in;
            hlen_q  <= hlen_d;
            llen_q  <= llen_d;
            sent_q  <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (rem_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            add_q   <= 1'b1;
            busy_q  <= 1'b1;
            sent_q  <= sent_q + REG_SIZE'(1);
            cnt_q   <= LEN_SIZE'(1);
            state_q <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (abort) begin
            add_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q >= hlen_q) begin
            // Pulse finished: account for it now so LOW can decide what follows.
            add_q   <= 1'b0;
            rem_q   <= rem_q - REG_SIZE'(1);
            cnt_q   <= LEN_SIZE'(1);
            state_q <= S_LOW;
          end else begin
            cnt_q <= cnt_q + LEN_SIZE'(1);
          end
        end
        S_LOW: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q >= llen_q) begin
            if (rem_q != '0) begin
              add_q   <= 1'b1;
              sent_q  <= sent_q + REG_SIZE'(1);
              cnt_q   <= LEN_SIZE'(1);
              state_q <= S_HIGH;
            end else begin
              // Trailing low time has elapsed, so the last ripple has settled.
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            cnt_q <= cnt_q + LEN_SIZE'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign add_sig   = add_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sent_cnt  = sent_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  localparam int RS = 4;
  localparam int LS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RS-1:0] count_in;
  logic [LS-1:0] hi_len;
  logic [LS-1:0] lo_len;
  logic          abort;
  logic          add_sig;
  logic          busy;
  logic          done;
  logic [RS-1:0] sent_cnt;
  logic [2:0]    state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  // expected {done latency, pulses, high cycles, busy cycles, first rise cycle}
  logic [63:0] exp_q[$];

  // Behavioural stand-in for counter_asyn: counts rising edges of add_sig.
  int cout_raw = 0;

  typedef struct {
    int cnt;
    int hi;
    int lo;
    bit ab;
    int lat;
    int high;
  } vec_t;

  vec_t vecs[8];

  pulse_train_gen #(.REG_SIZE(RS), .LEN_SIZE(LS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count_in  (count_in),
    .hi_len    (hi_len),
    .lo_len    (lo_len),
    .abort     (abort),
    .add_sig   (add_sig),
    .busy      (busy),
    .done      (done),
    .sent_cnt  (sent_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  always @(posedge add_sig) cout_raw <= cout_raw + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  // Starts one train and observes it edge by edge. inj_k > 0 re-asserts start
  // (with inj_cnt) after edge t+inj_k, which must be ignored.
  task automatic run_train(input int cnt, input int hi, input int lo, input bit ab,
                           input int exp_lat, input int exp_high,
                           input int inj_k, input int inj_cnt, input string tag);
    int k;
    int first_k;
    int high_c;
    int busy_c;
    int done_k;
    int base;
    logic [63:0] e;
    e = {16'(exp_lat), 16'(cnt), 16'(exp_high), 8'(exp_lat - 1), 8'((cnt > 0) ? 1 : 0)};
    exp_q.push_back(e);
    @(negedge clk);
    count_in = RS'(cnt);
    hi_len   = LS'(hi);
    lo_len   = LS'(lo);
    abort    = ab;
    start    = 1'b1;
    base     = cout_raw;
    @(negedge clk);               // edge t has passed
    start    = 1'b0;
    abort    = 1'b0;
    count_in = RS'($urandom_range(0, 15));
    hi_len   = LS'($urandom_range(0, 15));
    lo_len   = LS'($urandom_range(0, 15));
    first_k = 0; high_c = 0; busy_c = 0; done_k = 0;
    for (k = 1; k <= 300 && done_k == 0; k++) begin
      @(negedge clk);             // sample after edge t+k
      if (add_sig && first_k == 0) first_k = k;
      if (add_sig) high_c++;
      if (busy) busy_c++;
      if (done) done_k = k;
      if (k == inj_k) begin
        start    = 1'b1;
        count_in = RS'(inj_cnt);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, " done_latency"}, done_k, int'(e[63:48]));
      check({tag, " pulses"}, cout_raw - base, int'(e[47:32]));
      check({tag, " sent_cnt"}, int'(sent_cnt), int'(e[47:32]));
      check({tag, " high_cycles"}, high_c, int'(e[31:16]));
      check({tag, " busy_cycles"}, busy_c, int'(e[15:8]));
      check({tag, " first_rise"}, first_k, int'(e[7:0]));
    end
    @(negedge clk);
    check({tag, " done_one_cycle"}, int'(done), 0);
    check({tag, " sent_hold"}, int'(sent_cnt), cnt);
  endtask

  initial begin
    int k;
    int n_done;
    int he;
    int le;
    int c;
    int h;
    int l;

    vecs[0] = '{cnt: 5,  hi: 1,  lo: 1,  ab: 1'b0, lat: 11, high: 5};
    vecs[1] = '{cnt: 0,  hi: 1,  lo: 1,  ab: 1'b0, lat: 1,  high: 0};
    vecs[2] = '{cnt: 2,  hi: 0,  lo: 0,  ab: 1'b0, lat: 5,  high: 2};
    vecs[3] = '{cnt: 3,  hi: 3,  lo: 2,  ab: 1'b0, lat: 16, high: 9};
    vecs[4] = '{cnt: 15, hi: 1,  lo: 1,  ab: 1'b0, lat: 31, high: 15};
    vecs[5] = '{cnt: 1,  hi: 15, lo: 15, ab: 1'b0, lat: 31, high: 15};
    vecs[6] = '{cnt: 3,  hi: 2,  lo: 0,  ab: 1'b1, lat: 10, high: 6};
    vecs[7] = '{cnt: 4,  hi: 0,  lo: 5,  ab: 1'b0, lat: 25, high: 4};

    // ---------------- reset ----------------
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    count_in = '0; hi_len = '0; lo_len = '0;
    repeat (2) @(negedge clk);
    check("reset add_sig", int'(add_sig), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset sent_cnt", int'(sent_cnt), 0);
    check("reset state", int'(state_dbg), 0);
    rst = 1'b0;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 8; i++) begin
      run_train(vecs[i].cnt, vecs[i].hi, vecs[i].lo, vecs[i].ab,
                vecs[i].lat, vecs[i].high, 0, 0, $sformatf("vec%0d", i));
    end

    // ---------------- abort during the 4th HIGH ----------------
    @(negedge clk);
    count_in = 4'd10; hi_len = 4'd1; lo_len = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k <= 7; k++) @(negedge clk);
    check("abort pre add_sig", int'(add_sig), 1);
    check("abort pre sent_cnt", int'(sent_cnt), 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort add_sig", int'(add_sig), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort sent_cnt", int'(sent_cnt), 4);
    n_done = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || add_sig) n_done++;
    end
    check("abort quiet after", n_done, 0);
    run_train(1, 1, 1, 1'b0, 3, 1, 0, 0, "post_abort");

    // ---------------- ignored start mid-train ----------------
    run_train(4, 1, 1, 1'b0, 9, 4, 3, 7, "ignored_start");

    // ---------------- reset mid-train ----------------
    @(negedge clk);
    count_in = 4'd10; hi_len = 4'd1; lo_len = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k <= 3; k++) @(negedge clk);
    check("midrst pre add_sig", int'(add_sig), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst add_sig", int'(add_sig), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst sent_cnt", int'(sent_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst idle add_sig", int'(add_sig), 0);
    check("midrst idle busy", int'(busy), 0);

    // ---------------- random trains ----------------
    for (int i = 0; i < 200; i++) begin
      c = $urandom_range(0, 15);
      h = $urandom_range(0, 3);
      l = $urandom_range(0, 3);
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      run_train(c, h, l, 1'b0, 1 + c * (he + le), c * he, 0, 0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
